// File: rtl/pipeline_stage_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pipeline_stage_skid                                           |
// | Description : Valid/ready pipeline stage register with flush (bubble        |
// |               insertion) and an optional 2-entry skid buffer.               |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module pipeline_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  generate
    if (SKID) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_head;
      logic [WIDTH-1:0] r_skid;
      logic [WIDTH-1:0] w_head_nxt;
      logic [WIDTH-1:0] w_skid_nxt;
      logic             r_in_ready;
      logic             w_push;
      logic             w_pop;

      assign w_push = in_valid & r_in_ready;
      assign w_pop  = (r_state != EMPTY) & out_ready;

      always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
          EMPTY: begin
            if (w_push) begin
              w_state_nxt = ONE;
              w_head_nxt  = in_data;
            end
          end
          ONE: begin
            if (w_push && w_pop) begin
              w_head_nxt = in_data;
            end else if (w_push) begin
              w_state_nxt = TWO;
              w_skid_nxt  = in_data;
            end else if (w_pop) begin
              w_state_nxt = EMPTY;
              w_head_nxt  = BUBBLE;
            end
          end
          TWO: begin
            // in_ready is low here, so only a pop can occur
            if (w_pop) begin
              w_state_nxt = ONE;
              w_head_nxt  = r_skid;
              w_skid_nxt  = BUBBLE;
            end
          end
          default: begin
            w_state_nxt = EMPTY;
            w_head_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_state    <= EMPTY;
          r_head     <= BUBBLE;
          r_skid     <= BUBBLE;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_nxt;
          r_head     <= w_head_nxt;
          r_skid     <= w_skid_nxt;
          r_in_ready <= (w_state_nxt != TWO);
        end
      end

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != EMPTY);
      assign out_data  = r_head;
      assign occupancy = r_state;
    end else begin : g_single
      logic [WIDTH-1:0] r_head;
      logic             r_valid;
      logic             w_in_ready;
      logic             w_push;
      logic             w_pop;

      assign w_in_ready = ~r_valid | out_ready;
      assign w_push     = in_valid & w_in_ready;
      assign w_pop      = r_valid & out_ready;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_valid <= 1'b0;
          r_head  <= BUBBLE;
        end else if (w_push) begin
          r_valid <= 1'b1;
          r_head  <= in_data;
        end else if (w_pop) begin
          r_valid <= 1'b0;
          r_head  <= BUBBLE;
        end
      end

      assign in_ready  = w_in_ready;
      assign out_valid = r_valid;
      assign out_data  = r_head;
      assign occupancy = {1'b0, r_valid};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_pipeline_stage_skid                                        |
// | Description : Scoreboard bench for pipeline_stage_skid (SKID=1 and SKID=0). |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_pipeline_stage_skid;

  logic        clk;
  logic        reset;
  // skid instance (WIDTH=32)
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [1:0]  occ0;
  // single-entry instance (WIDTH=64)
  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [63:0] in_data1, out_data1;
  logic [1:0]  occ1;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] q0[$];
  logic [63:0] q1[$];

  pipeline_stage_skid #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occ0)
  );

  pipeline_stage_skid #(.WIDTH(64), .BUBBLE(64'h0), .SKID(1'b0)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every pop handshake must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && !flush0 && out_valid0 && out_ready0) begin
      if (q0.size() == 0) check("sb0_unexpected_pop", {32'h0, out_data0}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("sb0_data", {32'h0, out_data0}, {32'h0, q0.pop_front()});
    end
    if (!reset && !flush1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("sb1_unexpected_pop", out_data1, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("sb1_data", out_data1, q1.pop_front());
    end
  end

  initial begin
    reset = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 32'hDEAD_BEEF; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    // 1 reset with in_valid asserted
    repeat (2) step();
    check("rst_out_valid", {63'h0, out_valid0}, 64'h0);
    check("rst_out_data", {32'h0, out_data0}, 64'h0);
    check("rst_occ", {62'h0, occ0}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready0}, 64'h1);
    reset = 1'b0; in_valid0 = 1'b0;
    step();
    check("idle_occ", {62'h0, occ0}, 64'h0);

    // 2 streaming at full rate
    out_ready0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid0 = 1'b1; in_data0 = i; q0.push_back(i);
      step();
      check("strm_data", {32'h0, out_data0}, i);
      check("strm_occ", {62'h0, occ0}, 64'h1);
      check("strm_in_ready", {63'h0, in_ready0}, 64'h1);
    end
    in_valid0 = 1'b0;
    step();
    check("strm_drain_occ", {62'h0, occ0}, 64'h0);
    check("strm_drain_bubble", {32'h0, out_data0}, 64'h0);

    // 3 stall fill, then drain in order
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 32'h1111; q0.push_back(32'h1111);
    step();
    check("fill_occ1", {62'h0, occ0}, 64'h1);
    in_data0 = 32'h2222; q0.push_back(32'h2222);
    step();
    check("fill_occ2", {62'h0, occ0}, 64'h2);
    check("fill_in_ready", {63'h0, in_ready0}, 64'h0);
    check("fill_head", {32'h0, out_data0}, 64'h1111);
    in_data0 = 32'h3333; q0.push_back(32'h3333);
    step();
    check("stall_occ", {62'h0, occ0}, 64'h2);
    check("stall_hold", {32'h0, out_data0}, 64'h1111);
    out_ready0 = 1'b1;
    step();
    check("drain_b", {32'h0, out_data0}, 64'h2222);
    check("drain_in_ready", {63'h0, in_ready0}, 64'h1);
    step();
    check("drain_c", {32'h0, out_data0}, 64'h3333);
    in_valid0 = 1'b0;
    step();
    check("drain_occ", {62'h0, occ0}, 64'h0);
    check("drain_sb_empty", q0.size(), 64'h0);

    // 4 flush at occupancy 2 with a push and pop offered
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 32'hAAAA;
    step();
    in_data0 = 32'hBBBB;
    step();
    check("pre_flush_occ", {62'h0, occ0}, 64'h2);
    flush0 = 1'b1; in_data0 = 32'hCCCC; out_ready0 = 1'b1;
    step();
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    check("flush_occ", {62'h0, occ0}, 64'h0);
    check("flush_out_valid", {63'h0, out_valid0}, 64'h0);
    check("flush_bubble", {32'h0, out_data0}, 64'h0);
    check("flush_in_ready", {63'h0, in_ready0}, 64'h1);
    // flush at occupancy 1 while a push is actually accepted
    in_valid0 = 1'b1; in_data0 = 32'h5555;
    step();
    flush0 = 1'b1; in_data0 = 32'h6666;
    step();
    flush0 = 1'b0; in_valid0 = 1'b0;
    check("flush1_occ", {62'h0, occ0}, 64'h0);
    check("flush1_bubble", {32'h0, out_data0}, 64'h0);
    step();
    check("flush1_absent", {63'h0, out_valid0}, 64'h0);

    // 5 reset and flush together
    in_valid0 = 1'b1; in_data0 = 32'h7777;
    step();
    check("pre_rf_occ", {62'h0, occ0}, 64'h1);
    reset = 1'b1; flush0 = 1'b1; in_data0 = 32'h8888;
    step();
    reset = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0;
    check("rf_occ", {62'h0, occ0}, 64'h0);
    check("rf_out_valid", {63'h0, out_valid0}, 64'h0);
    check("rf_bubble", {32'h0, out_data0}, 64'h0);
    check("rf_in_ready", {63'h0, in_ready0}, 64'h1);
    out_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 32'h9999; q0.push_back(32'h9999);
    step();
    in_valid0 = 1'b0;
    check("post_rf_data", {32'h0, out_data0}, 64'h9999);
    step();
    check("post_rf_sb_empty", q0.size(), 64'h0);

    // 6 SKID=0: combinational in_ready and same-edge head replacement
    check("s0_empty_in_ready", {63'h0, in_ready1}, 64'h1);
    in_valid1 = 1'b1; in_data1 = 64'h0123_4567_89AB_CDEF; q1.push_back(64'h0123_4567_89AB_CDEF);
    step();
    in_valid1 = 1'b0;
    check("s0_head", out_data1, 64'h0123_4567_89AB_CDEF);
    check("s0_stall_in_ready", {63'h0, in_ready1}, 64'h0);
    out_ready1 = 1'b1;
    #1;
    check("s0_comb_in_ready", {63'h0, in_ready1}, 64'h1);
    in_valid1 = 1'b1; in_data1 = 64'hFEDC_BA98_7654_3210; q1.push_back(64'hFEDC_BA98_7654_3210);
    step();
    in_valid1 = 1'b0;
    check("s0_replace", out_data1, 64'hFEDC_BA98_7654_3210);
    check("s0_occ", {62'h0, occ1}, 64'h1);
    out_ready1 = 1'b0;
    #1;
    check("s0_comb_in_ready_low", {63'h0, in_ready1}, 64'h0);
    out_ready1 = 1'b1;
    step();
    check("s0_drain_bubble", out_data1, 64'h0);
    check("s0_drain_occ", {62'h0, occ1}, 64'h0);
    check("s0_sb_empty", q1.size(), 64'h0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
